// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: channel modes and the per-channel
// configuration word carried from the write port into each channel.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;

  // Widest period field a channel can be built with; narrower builds zero-extend.
  localparam int LED_MAX_PERIOD_BITS = 16;

  typedef logic [LED_MAX_PERIOD_BITS-1:0] led_period_t;

  typedef struct packed {
    led_mode_e   mode;
    led_period_t period;
  } led_cfg_t;

  // A zero period would never match phase == period-1, so it is promoted to 1.
  function automatic led_period_t led_fix_period(input led_period_t p);
    return (p == '0) ? led_period_t'(1) : p;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode/period and runs the blink toggle or the
// triangular breathe duty ramp on the shared tick, producing a raw level.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS    = 7,
  parameter int PERIOD_BITS = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wr,
  input  led_cfg_t            cfg,
  output logic                level
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  led_cfg_t               cfg_q;
  logic [PERIOD_BITS-1:0] phase;
  logic                   blink_q;
  logic [PWM_BITS-1:0]    duty;
  logic                   dir_up;
  logic                   wrap;
  logic                   timed;

  assign wrap  = (led_period_t'(phase) == (cfg_q.period - led_period_t'(1)));
  assign timed = (cfg_q.mode == LED_BLINK) || (cfg_q.mode == LED_BREATHE);

  // A write takes priority over a tick arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '{mode: LED_OFF, period: led_period_t'(1)};
      phase   <= '0;
      blink_q <= 1'b0;
      duty    <= '0;
      dir_up  <= 1'b1;
    end else if (wr) begin
      cfg_q   <= '{mode: cfg.mode, period: led_fix_period(cfg.period)};
      phase   <= '0;
      blink_q <= 1'b0;
      duty    <= '0;
      dir_up  <= 1'b1;
    end else if (tick && timed) begin
      if (wrap) begin
        phase <= '0;
        if (cfg_q.mode == LED_BLINK) begin
          blink_q <= ~blink_q;
        end else if (dir_up) begin
          if (duty == DUTY_MAX) begin
            dir_up <= 1'b0;
            duty   <= duty - PWM_BITS'(1);
          end else begin
            duty <= duty + PWM_BITS'(1);
          end
        end else if (duty == '0) begin
          dir_up <= 1'b1;
          duty   <= duty + PWM_BITS'(1);
        end else begin
          duty <= duty - PWM_BITS'(1);
        end
      end else begin
        phase <= phase + PERIOD_BITS'(1);
      end
    end
  end

  always_comb begin
    level = 1'b0;
    case (cfg_q.mode)
      LED_ON:      level = 1'b1;
      LED_BLINK:   level = blink_q;
      LED_BREATHE: level = (pwm_cnt < duty);
      default:     level = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM counter,
// write decode into N_CH channels, and a registered polarity-corrected output.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CLK_HZ      = 27000000,
  parameter int TICK_HZ     = 1000,
  parameter int PWM_BITS    = 7,
  parameter int PERIOD_BITS = 12,
  parameter bit ACTIVE_LOW  = 1'b1,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [CH_W-1:0]        i_wr_ch,
  input  logic [1:0]             i_wr_mode,
  input  logic [PERIOD_BITS-1:0] i_wr_period,
  output logic [N_CH-1:0]        o_led,
  output logic                   o_tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0]    presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_CH-1:0]     level;
  led_cfg_t            wr_cfg;

  assign o_tick = (presc == CNT_W'(DIV - 1));

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= o_tick ? '0 : presc + CNT_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // PERIOD_BITS is expected not to exceed LED_MAX_PERIOD_BITS.
  assign wr_cfg = '{mode: led_mode_e'(i_wr_mode), period: led_period_t'(i_wr_period)};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic wr_sel;
    // Channel indices at or beyond N_CH never match, so such writes are dropped.
    assign wr_sel = i_wr_en && (i_wr_ch == CH_W'(g));

    led_channel #(
      .PWM_BITS    (PWM_BITS),
      .PERIOD_BITS (PERIOD_BITS)
    ) u_ch (
      .clk     (i_sys_clk),
      .rst_n   (i_rst_n),
      .tick    (o_tick),
      .pwm_cnt (pwm_cnt),
      .wr      (wr_sel),
      .cfg     (wr_cfg),
      .level   (level[g])
    );
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_led <= {N_CH{ACTIVE_LOW}};
    end else begin
      o_led <= level ^ {N_CH{ACTIVE_LOW}};
    end
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Multi-channel, runtime-configurable LED pattern generator for the Tang9K board.
- Each channel is independently programmed to OFF, ON, BLINK (programmable half-period) or BREATHE (triangular PWM ramp with programmable step rate).
- All channels share one tick prescaler and one PWM counter.
- Sits beside the system controller and is driven by a simple single-cycle write strobe from the SPI register block.

Parameters:
- N_CH, 4, number of LED channels (1..16).
- CLK_HZ, 27000000, system clock frequency in Hz.
- TICK_HZ, 1000, pattern time base; prescaler divisor DIV = CLK_HZ/TICK_HZ (must be >= 2).
- PWM_BITS, 7, PWM counter and breathe duty width.
- PERIOD_BITS, 12, width of the per-channel period field, in ticks.
- ACTIVE_LOW, 1, 1 = outputs inverted for active-low board LEDs.

Ports:
- i_sys_clk  in  1  system clock. Single clock domain.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_wr_en  in  1  one-cycle config write strobe.
- i_wr_ch  in  $clog2(N_CH) (min 1)  target channel index.
- i_wr_mode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- i_wr_period  in  PERIOD_BITS  BLINK half-period, or BREATHE ticks per duty step.
- o_led  out  N_CH  registered LED drive, polarity set by ACTIVE_LOW.
- o_tick  out  1  one-cycle pulse per prescaler wrap (debug / test).

Behaviour:
- Reset (async, i_rst_n=0):
  - All channel modes = OFF; period = 1; phase = 0; level = 0; duty = 0; dir = up.
  - Prescaler = 0; PWM counter = 0; o_tick = 0.
  - o_led = all ACTIVE_LOW (LEDs dark).
  - Reset asserted mid-pattern aborts immediately; no state is retained.
- Prescaler:
  - Counts 0..DIV-1, then wraps to 0.
  - o_tick = 1 for exactly the cycle the count equals DIV-1; one tick every DIV cycles.
- PWM counter:
  - PWM_BITS wide, free-running, increments every cycle, wraps 2^PWM_BITS-1 -> 0.
- Write:
  - When i_wr_en=1 and i_wr_ch < N_CH, that channel latches mode and period, and clears phase, level, duty and dir (dir = up).
  - Period 0 is stored as 1.
  - A write with i_wr_ch >= N_CH is ignored.
  - The new mode drives the internal level from the next cycle.
- Write/tick collision: a write and a tick in the same cycle on the same channel -> the write wins and that tick is dropped for that channel only.
- OFF: level = 0. ON: level = 1.
- BLINK:
  - On each tick, phase increments.
  - When phase == period-1 on a tick: phase -> 0 and level toggles.
  - Result: first toggle occurs period ticks after the write; full cycle = 2*period ticks.
- BREATHE:
  - On each tick, phase increments. When phase == period-1 on a tick: phase -> 0 and duty steps by one.
  - Going up: when duty == 2^PWM_BITS-1, dir flips to down and duty decrements on that step (no duplicate peak).
  - Going down: when duty == 0, dir flips to up and duty increments on that step.
  - level = (pwm_cnt < duty). So duty 0 = fully dark; max duty = lit for all but one PWM count.
- Output:
  - o_led[i] <= level_i XOR ACTIVE_LOW.
  - One register stage: o_led reflects a level change one cycle later.
  - A write is visible on o_led two cycles after the i_wr_en cycle.
- Arithmetic:
  - Phase counters are PERIOD_BITS wide and compare against the stored period.
  - No arithmetic overflow is possible; duty saturation is handled by the direction flips.

Decomposition:
- Package led_pkg:
  - Mode enum led_mode_e (LED_OFF, LED_ON, LED_BLINK, LED_BREATHE), 2 bits.
  - Per-channel config struct: mode plus period.
- Natural sub-module: led_channel, one instance per channel, generated N_CH times.
  - Holds mode, period, phase, level, duty and dir.
  - Inputs: tick, shared pwm_cnt, write strobe qualified by channel select, mode, period.
  - Output: level.
- Top level: prescaler, PWM counter, write decode, output polarity register.

Test Plan (CLK_HZ=100, TICK_HZ=10 so DIV=10, PWM_BITS=3, N_CH=4, ACTIVE_LOW=1):
- Reset, no writes -> o_led=4'b1111 indefinitely; o_tick pulses every 10 cycles.
- Write ch1 BLINK period=3 -> o_led[1] low (LED lit) after 3 ticks, high after 6, low after 9; 30-cycle half-period; other channels stay 1.
- Write ch2 BREATHE period=1 -> duty sequence per tick 1..7,6..0,1. Measured low-time per 8-cycle PWM frame equals duty.
- Write ch0 ON, then ch0 OFF with i_wr_en in the same cycle as o_tick -> o_led[0]=0 two cycles after the first write, back to 1 two cycles after the second; no tick-driven glitch.
- Write i_wr_ch=3 with mode BLINK and period=0 -> behaves as period=1 (toggle every tick). Then a write with i_wr_ch out of range (N_CH=3 build, ch=3) -> no change on any output.
- Assert i_rst_n=0 mid-breathe, asynchronously between clock edges -> o_led=all 1 immediately. After release, all channels OFF, and first o_tick occurs 10 cycles later.
